jt51_timer_ctrl: RTL and testbench

- CPU-side register front end for the timer pair; sits directly upstream of the timer block and drives all of its inputs.
- Decodes YM2151-style address/data bus writes to registers 0x10/0x11/0x12/0x14 into timer preset values, single-cycle command pulses and level enables.
- Generates the busy flag, the status read byte, and the CSM key-on pulse derived from timer A overflow.

---
 rtl/jt51_timer_ctrl.sv | 138 +++++++++++++
 tb/tb_jt51_timer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jt51_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jt51_timer_ctrl : YM2151 CPU register front end driving the timer pair.    |
// | Optional macro JT51_CSM_EN adds composite sine mode (csm / csm_keyon).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jt51_timer_ctrl #(
   parameter int BUSY_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       flag_A,
   input  logic       flag_B,
   input  logic       overflow_A,
   output logic [9:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       clr_run_A,
   output logic       clr_run_B,
   output logic       set_run_A,
   output logic       set_run_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic       enable_irq_A,
   output logic       enable_irq_B,
   output logic       csm,
   output logic       csm_keyon
);

   localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES);

   logic       strobe;
   logic       strobe_q;
   logic       wr_ev;
   logic       data_ev;
   logic       busy;
   logic       run_a;
   logic       run_b;
   logic [7:0] addr;
   logic [7:0] busy_cnt;

   // strobe_q resets to "active" so a strobe held low across reset release is not an edge
   assign strobe  = ~(cs_n | wr_n);
   assign wr_ev   = strobe & ~strobe_q;
   assign data_ev = wr_ev & a0;
   assign busy    = (busy_cnt != 8'd0);

   assign set_run_A = 1'b0;
   assign set_run_B = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         strobe_q     <= 1'b1;
         addr         <= 8'd0;
         value_A      <= 10'd0;
         value_B      <= 8'd0;
         run_a        <= 1'b0;
         run_b        <= 1'b0;
         enable_irq_A <= 1'b0;
         enable_irq_B <= 1'b0;
         load_A       <= 1'b0;
         load_B       <= 1'b0;
         clr_run_A    <= 1'b0;
         clr_run_B    <= 1'b0;
         clr_flag_A   <= 1'b0;
         clr_flag_B   <= 1'b0;
         busy_cnt     <= 8'd0;
         dout         <= 8'd0;
      end else begin
         strobe_q   <= strobe;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         clr_run_A  <= 1'b0;
         clr_run_B  <= 1'b0;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;

         if (wr_ev && !a0)
            addr <= din;

         if (data_ev) begin
            case (addr)
               8'h10: value_A[9:2] <= din;
               8'h11: value_A[1:0] <= din[1:0];
               8'h12: value_B      <= din;
               8'h14: begin
                  // run bits act on transitions only: 0->1 loads, 1->0 stops
                  load_A       <= din[0] & ~run_a;
                  clr_run_A    <= ~din[0] & run_a;
                  load_B       <= din[1] & ~run_b;
                  clr_run_B    <= ~din[1] & run_b;
                  run_a        <= din[0];
                  run_b        <= din[1];
                  enable_irq_A <= din[2];
                  enable_irq_B <= din[3];
                  clr_flag_A   <= din[4];
                  clr_flag_B   <= din[5];
               end
               default: ;
            endcase
         end

         if (data_ev)
            busy_cnt <= BUSY_LOAD;
         else if (busy)
            busy_cnt <= busy_cnt - 8'd1;

         dout <= {busy, 5'b00000, flag_B, flag_A};
      end
   end

`ifdef JT51_CSM_EN
   // key-on uses csm as it stood before any same-cycle register write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csm       <= 1'b0;
         csm_keyon <= 1'b0;
      end else begin
         csm_keyon <= overflow_A & csm;
         if (data_ev && (addr == 8'h14))
            csm <= din[7];
      end
   end
`else
   logic unused_overflow;
   assign unused_overflow = overflow_A;
   assign csm             = 1'b0;
   assign csm_keyon       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt51_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jt51_timer_ctrl : directed plus random checks against a cycle model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_jt51_timer_ctrl;

   localparam int BUSY = 32;
`ifdef JT51_CSM_EN
   localparam bit CSM_ON = 1'b1;
`else
   localparam bit CSM_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, cs_n, wr_n, a0;
   logic [7:0] din;
   logic       flag_A, flag_B, overflow_A;
   logic [7:0] dout;
   logic [9:0] value_A;
   logic [7:0] value_B;
   logic       load_A, load_B, clr_run_A, clr_run_B, set_run_A, set_run_B;
   logic       clr_flag_A, clr_flag_B, enable_irq_A, enable_irq_B, csm, csm_keyon;

   always #5 clk = ~clk;

   jt51_timer_ctrl #(.BUSY_CYCLES(BUSY)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
      .dout(dout), .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
      .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
      .clr_run_A(clr_run_A), .clr_run_B(clr_run_B), .set_run_A(set_run_A),
      .set_run_B(set_run_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
      .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
      .csm(csm), .csm_keyon(csm_keyon)
   );

   int    errors = 0;
   int    checks = 0;
   string cur_tag = "init";

   // reference model state: register contents plus a cycle timeline
   int   cyc = 0;
   int   last_ev = -100000;
   bit   prev_act = 1'b1;
   int   m_addr = 0, m_va = 0, m_vb = 0;
   bit   m_ra = 0, m_rb = 0, m_ea = 0, m_eb = 0, m_csm = 0;
   logic [7:0] e_dout = 8'd0;
   bit   e_la = 0, e_lb = 0, e_ca = 0, e_cb = 0, e_fa = 0, e_fb = 0, e_key = 0;
   int   busy_seen = 0, loada_seen = 0, clra_seen = 0;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit cs, input bit wr, input bit a,
                        input logic [7:0] d, input bit fa, input bit fb, input bit ov);
      bit act;
      bit bz;
      e_la = 0; e_lb = 0; e_ca = 0; e_cb = 0; e_fa = 0; e_fb = 0;
      if (!r) begin
         m_addr = 0; m_va = 0; m_vb = 0;
         m_ra = 0; m_rb = 0; m_ea = 0; m_eb = 0; m_csm = 0;
         last_ev = -100000; prev_act = 1'b1;
         e_dout = 8'd0; e_key = 0;
      end else begin
         act    = !cs && !wr;
         bz     = (cyc - last_ev >= 1) && (cyc - last_ev <= BUSY);
         e_dout = {bz, 5'b00000, fb, fa};
         e_key  = ov && m_csm;
         if (act && !prev_act) begin
            if (!a) m_addr = d;
            else begin
               last_ev = cyc;
               if (m_addr == 16)      m_va = d * 4 + m_va % 4;
               else if (m_addr == 17) m_va = (m_va / 4) * 4 + d % 4;
               else if (m_addr == 18) m_vb = d;
               else if (m_addr == 20) begin
                  e_la = d[0] && !m_ra;  e_ca = !d[0] && m_ra;  m_ra = d[0];
                  e_lb = d[1] && !m_rb;  e_cb = !d[1] && m_rb;  m_rb = d[1];
                  m_ea = d[2]; m_eb = d[3]; e_fa = d[4]; e_fb = d[5];
                  if (CSM_ON) m_csm = d[7];
               end
            end
         end
         prev_act = act;
      end
      cyc++;
   endtask

   task automatic step(input bit r, input bit cs, input bit wr, input bit a,
                       input logic [7:0] d, input bit fa, input bit fb, input bit ov);
      rst_n = r; cs_n = cs; wr_n = wr; a0 = a; din = d;
      flag_A = fa; flag_B = fb; overflow_A = ov;
      model(r, cs, wr, a, d, fa, fb, ov);
      @(posedge clk);
      #1;
      chk(cur_tag,
          {dout, value_A, value_B, load_A, load_B, clr_run_A, clr_run_B, set_run_A,
           set_run_B, clr_flag_A, clr_flag_B, enable_irq_A, enable_irq_B, csm, csm_keyon},
          {e_dout, 10'(m_va), 8'(m_vb), e_la, e_lb, e_ca, e_cb, 1'b0,
           1'b0, e_fa, e_fb, m_ea, m_eb, m_csm, e_key});
      busy_seen  += int'(dout[7]);
      loada_seen += int'(load_A);
      clra_seen  += int'(clr_run_A);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 1, 0, 8'h00, 0, 0, 0);
   endtask

   task automatic wr(input bit a, input logic [7:0] d);
      step(1, 0, 0, a, d, 0, 0, 0);
      step(1, 1, 1, a, d, 0, 0, 0);
   endtask

   initial begin
      logic [7:0] addrs [5];
      bit         rr, rc, rw, ra, rfa, rfb, rov;
      logic [7:0] rd;
      addrs[0] = 8'h10; addrs[1] = 8'h11; addrs[2] = 8'h12; addrs[3] = 8'h14; addrs[4] = 8'h13;

      cur_tag = "reset";
      step(0, 1, 1, 0, 8'h00, 0, 0, 0);
      step(0, 1, 1, 0, 8'h00, 1, 1, 1);
      chk("reset_dout", dout, 8'h00);
      idle(1);

      cur_tag = "value_a";
      wr(0, 8'h10); wr(1, 8'hAB); wr(0, 8'h11);
      step(1, 0, 0, 1, 8'h03, 0, 0, 0);
      chk("value_a_2af", value_A, 10'h2AF);
      chk("value_a_noload", load_A, 1'b0);
      step(1, 1, 1, 1, 8'h03, 0, 0, 0);

      cur_tag = "run_bits";
      idle(40);
      wr(0, 8'h14);
      loada_seen = 0; clra_seen = 0;
      wr(1, 8'h01); wr(1, 8'h01); wr(1, 8'h00);
      chk("load_a_once", loada_seen, 1);
      chk("clr_run_a_once", clra_seen, 1);

      cur_tag = "flags_irq";
      step(1, 0, 0, 1, 8'h3C, 0, 0, 0);
      chk("clr_flags", {clr_flag_A, clr_flag_B, enable_irq_A, enable_irq_B, load_A, load_B}, 6'b111100);
      step(1, 1, 1, 1, 8'h3C, 0, 0, 0);
      wr(1, 8'h00);

      cur_tag = "busy";
      wr(0, 8'h20); idle(40);
      busy_seen = 0; wr(1, 8'h55); idle(40);
      chk("busy_32", busy_seen, 32);
      busy_seen = 0; wr(1, 8'h55); idle(8); wr(1, 8'h55); idle(45);
      chk("busy_extend_42", busy_seen, 42);
      busy_seen = 0; wr(1, 8'h55); idle(8); wr(0, 8'h20); idle(45);
      chk("busy_addr_only", busy_seen, 32);

      cur_tag = "csm";
      wr(0, 8'h14); wr(1, 8'h81); idle(2);
      step(1, 1, 1, 0, 8'h00, 0, 0, 1);
      chk("csm_keyon_on", csm_keyon, CSM_ON);
      idle(1);
      chk("csm_keyon_1cyc", csm_keyon, 1'b0);
      wr(1, 8'h00); idle(2);
      step(1, 1, 1, 0, 8'h00, 0, 0, 1);
      chk("csm_keyon_off", csm_keyon, 1'b0);

      cur_tag = "hold";
      idle(2); loada_seen = 0;
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 8'h01, 0, 0, 0);
      step(1, 1, 1, 1, 8'h01, 0, 0, 0); idle(2);
      chk("hold_single_event", loada_seen, 1);

      cur_tag = "reset_busy";
      wr(1, 8'h0C); wr(0, 8'h10); wr(1, 8'hFF); idle(3);
      step(0, 1, 1, 0, 8'h00, 1, 1, 0);
      chk("rst_clears", {dout, value_A, enable_irq_A, enable_irq_B}, 20'd0);
      step(1, 0, 0, 0, 8'h12, 0, 0, 0);
      step(0, 0, 0, 0, 8'h12, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h12, 0, 0, 0);
      step(1, 1, 1, 0, 8'h12, 0, 0, 0);
      wr(1, 8'h77);
      chk("held_through_reset", value_B, 8'h00);

      cur_tag = "random";
      for (int i = 0; i < 400; i++) begin
         rr  = ($urandom % 64) != 0;
         rc  = ($urandom % 8) == 0;
         rw  = $urandom % 2;
         ra  = $urandom % 2;
         rd  = ra ? 8'($urandom) : addrs[$urandom % 5];
         rfa = $urandom % 2;
         rfb = $urandom % 2;
         rov = ($urandom % 4) == 0;
         step(rr, rc, rw, ra, rd, rfa, rfb, rov);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
